keypad_scan: RTL and testbench

//  Scans a 4x4 matrix keypad on the devboard: drives one row low at a time, reads the

---
 rtl/keypad_pkg.sv | 37 +++
 rtl/keypad_scan_if.sv | 17 +
 rtl/keypad_row_scan.sv | 79 +++++++
 rtl/keypad_scan.sv | 119 +++++++++++
 tb/tb_keypad_scan.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CANDIDATE,
    ST_PRESSED,
    ST_RELEASING
  } kp_state_e;

  typedef enum logic [1:0] {
    SCAN_NONE,
    SCAN_KEY,
    SCAN_MULTI
  } scan_res_e;

  function automatic logic [2:0] count_pressed(input logic [NUM_COLS-1:0] p);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NUM_COLS; i++) n = n + 3'(p[i]);
    return n;
  endfunction

  // Lowest pressed column wins, matching the row-major priority of the scan.
  function automatic logic [1:0] first_col(input logic [NUM_COLS-1:0] p);
    logic [1:0] idx;
    idx = '0;
    for (int i = NUM_COLS - 1; i >= 0; i--) begin
      if (p[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad matrix pins plus the key report / entry-register bus.
interface keypad_scan_if;
  import keypad_pkg::*;

  logic [NUM_COLS-1:0] col_in;
  logic [NUM_ROWS-1:0] row_out;
  logic                clear;
  logic [3:0]          key_code;
  logic                key_valid;
  logic                key_held;
  logic [15:0]         entry;

  modport slave  (input  col_in, clear,
                  output row_out, key_code, key_valid, key_held, entry);
  modport master (output col_in, clear,
                  input  row_out, key_code, key_valid, key_held, entry);
endinterface

// File: rtl/keypad_row_scan.sv
// Row sequencer: dwell timing, row drive, column synchroniser and per-scan key tally.
module keypad_row_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_COLS-1:0] col_i,
  output logic [NUM_ROWS-1:0] row_o,
  output logic                scan_done_o,
  output scan_res_e           scan_result_o,
  output logic [3:0]          scan_code_o
);

  logic [SCAN_DIV_W-1:0] dwell_q;
  logic [1:0]            row_q;
  logic [NUM_COLS-1:0]   col_s1_q, col_s2_q;
  logic [1:0]            acc_cnt_q, acc_cnt_d;
  logic [3:0]            acc_code_q, acc_code_d;
  logic                  scan_done_q;
  scan_res_e             scan_result_q, res_d;
  logic [3:0]            scan_code_q;
  logic                  sample;
  logic [NUM_COLS-1:0]   pressed;
  logic [2:0]            row_cnt, total;

  assign sample  = &dwell_q;
  assign pressed = ~col_s2_q;
  assign row_cnt = count_pressed(pressed);
  assign total   = {1'b0, acc_cnt_q} + row_cnt;

  // Key count saturates at 2: anything beyond one key is just MULTI.
  always_comb begin
    acc_code_d = acc_code_q;
    if (acc_cnt_q == 2'd0 && row_cnt != 3'd0) acc_code_d = {row_q, first_col(pressed)};
    acc_cnt_d = (total >= 3'd2) ? 2'd2 : total[1:0];
    res_d = (acc_cnt_d == 2'd0) ? SCAN_NONE :
            (acc_cnt_d == 2'd1) ? SCAN_KEY  : SCAN_MULTI;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dwell_q       <= '0;
      row_q         <= '0;
      col_s1_q      <= '1;
      col_s2_q      <= '1;
      acc_cnt_q     <= '0;
      acc_code_q    <= '0;
      scan_done_q   <= 1'b0;
      scan_result_q <= SCAN_NONE;
      scan_code_q   <= '0;
    end else begin
      dwell_q     <= dwell_q + 1'b1;
      col_s1_q    <= col_i;
      col_s2_q    <= col_s1_q;
      scan_done_q <= 1'b0;
      if (sample) begin
        row_q <= row_q + 2'd1;
        if (row_q == 2'd3) begin
          scan_done_q   <= 1'b1;
          scan_result_q <= res_d;
          scan_code_q   <= acc_code_d;
          acc_cnt_q     <= '0;
          acc_code_q    <= '0;
        end else begin
          acc_cnt_q  <= acc_cnt_d;
          acc_code_q <= acc_code_d;
        end
      end
    end
  end

  assign row_o         = ~(4'b0001 << row_q);
  assign scan_done_o   = scan_done_q;
  assign scan_result_o = scan_result_q;
  assign scan_code_o   = scan_code_q;

endmodule

// File: rtl/keypad_scan.sv
// Keypad front end: debounces whole-scan results and keeps the 4-digit entry register.
//  state        | meaning
//  ST_IDLE      | no key down, waiting for a single-key scan
//  ST_CANDIDATE | same key seen for cnt consecutive scans, not yet accepted
//  ST_PRESSED   | key accepted and held
//  ST_RELEASING | empty scans counted toward release
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV_W     = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input logic          clk,
  input logic          reset_n,
  keypad_scan_if.slave kp
);

  localparam logic [3:0] DB = 4'(DEBOUNCE_SCANS);

  logic       scan_done;
  scan_res_e  scan_result;
  logic [3:0] scan_code;

  kp_state_e  state_q, state_d;
  logic [3:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] key_code_q;
  logic       key_valid_q, key_held_q;
  logic [15:0] entry_q;
  logic       accept, release_done;

  keypad_row_scan #(.SCAN_DIV_W(SCAN_DIV_W)) u_row_scan (
    .clk          (clk),
    .reset_n      (reset_n),
    .col_i        (kp.col_in),
    .row_o        (kp.row_out),
    .scan_done_o  (scan_done),
    .scan_result_o(scan_result),
    .scan_code_o  (scan_code)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      entry_q     <= '0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_valid_q <= accept;
      if (accept) key_code_q <= scan_code;
      if (accept) key_held_q <= 1'b1;
      else if (release_done) key_held_q <= 1'b0;
      if (kp.clear) entry_q <= '0;
      else if (accept) entry_q <= {entry_q[11:0], scan_code};
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    if (scan_done) begin
      unique case (state_q)
        ST_IDLE: begin
          if (scan_result == SCAN_KEY) begin
            cand_d  = scan_code;
            cnt_d   = 4'd1;
            state_d = (DB == 4'd1) ? ST_PRESSED : ST_CANDIDATE;
          end
        end
        ST_CANDIDATE: begin
          if (scan_result == SCAN_KEY) begin
            if (scan_code == cand_q) begin
              cnt_d = cnt_q + 4'd1;
              if ((cnt_q + 4'd1) == DB) state_d = ST_PRESSED;
            end else begin
              cand_d = scan_code;
              cnt_d  = 4'd1;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_PRESSED: begin
          if (scan_result == SCAN_NONE) begin
            cnt_d   = 4'd1;
            state_d = (DB == 4'd1) ? ST_IDLE : ST_RELEASING;
          end
        end
        ST_RELEASING: begin
          if (scan_result == SCAN_NONE) begin
            cnt_d = cnt_q + 4'd1;
            if ((cnt_q + 4'd1) == DB) state_d = ST_IDLE;
          end else begin
            state_d = ST_PRESSED;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    accept       = (state_q == ST_IDLE || state_q == ST_CANDIDATE) && (state_d == ST_PRESSED);
    release_done = (state_q == ST_PRESSED || state_q == ST_RELEASING) && (state_d == ST_IDLE);
  end

  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;
  assign kp.entry     = entry_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a keypad model on the matrix pins, a scan-level reference model and per-cycle compare.
`timescale 1ns/1ps
module tb_keypad_scan;

  localparam int SDW   = 3;
  localparam int DB    = 2;
  localparam int DWELL = 8;
  localparam int SCAN  = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [15:0] keys = 16'h0000;
  logic clr = 1'b0;
  logic [3:0] col_drv;

  keypad_scan_if bus();

  keypad_scan #(.SCAN_DIV_W(SDW), .DEBOUNCE_SCANS(DB)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .kp     (bus)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key ties its column to whichever row is driven low.
  always_comb begin
    col_drv = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!bus.row_out[r])
        for (int c = 0; c < 4; c++)
          if (keys[4*r+c]) col_drv[c] = 1'b0;
  end
  assign bus.col_in = col_drv;
  assign bus.clear  = clr;

  // Reference model: works on whole scans of the held key set.
  int          edge_cnt = 0;
  bit          held = 0, acc = 0, pend = 0;
  int          run_len = 0, none_len = 0, pend_kind = 0;
  logic [3:0]  run_key = 4'h0, pend_code = 4'h0;
  logic        exp_valid = 1'b0, exp_held = 1'b0;
  logic [3:0]  exp_code = 4'h0;
  logic [15:0] exp_entry = 16'h0000;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cnt = 0; held = 0; run_len = 0; none_len = 0; pend = 0;
      exp_valid = 1'b0; exp_code = 4'h0; exp_held = 1'b0; exp_entry = 16'h0000;
    end else begin
      edge_cnt++;
      acc = 0;
      exp_valid = 1'b0;
      if (pend) begin
        pend = 0;
        if (!held) begin
          if (pend_kind == 1) begin
            run_len = (run_len > 0 && run_key == pend_code) ? run_len + 1 : 1;
            run_key = pend_code;
            if (run_len == DB) begin
              acc = 1; held = 1; none_len = 0; run_len = 0;
            end
          end else begin
            run_len = 0;
          end
        end else begin
          if (pend_kind == 0) begin
            none_len++;
            if (none_len == DB) held = 0;
          end else begin
            none_len = 0;
          end
        end
      end
      if (acc) begin
        exp_valid = 1'b1;
        exp_code  = run_key;
      end
      exp_held = held;
      if (clr) exp_entry = 16'h0000;
      else if (acc) exp_entry = {exp_entry[11:0], run_key};
      if (edge_cnt % SCAN == 0) begin
        pend = 1;
        pend_kind = ($countones(keys) == 0) ? 0 : ($countones(keys) == 1) ? 1 : 2;
        pend_code = 4'h0;
        for (int i = 15; i >= 0; i--) if (keys[i]) pend_code = 4'(i);
      end
    end
  end

  int n_cmp = 0, n_bad = 0, n_valid = 0;
  logic [3:0] last_code = 4'h0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] exp_row;
    exp_row = ~(4'b0001 << ((edge_cnt / DWELL) % 4));
    check("row_out",   {12'h0, bus.row_out},  {12'h0, exp_row});
    check("key_valid", {15'h0, bus.key_valid}, {15'h0, exp_valid});
    check("key_code",  {12'h0, bus.key_code}, {12'h0, exp_code});
    check("key_held",  {15'h0, bus.key_held}, {15'h0, exp_held});
    check("entry",     bus.entry,             exp_entry);
    if (reset_n && bus.key_valid) begin
      n_valid++;
      last_code = bus.key_code;
    end
  end

  task automatic wait_boundary();
    do @(negedge clk); while (edge_cnt % SCAN != 0);
  endtask

  task automatic set_keys(input logic [15:0] mask);
    wait_boundary();
    #1 keys = mask;
  endtask

  task automatic press_release(input int k);
    set_keys(16'(1) << k);
    wait_boundary();
    set_keys(16'h0000);
    repeat (3) wait_boundary();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, r, a, b, hold;
    logic [15:0] m;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Idle scanning: row walk and no reports
    check("row0", {12'h0, bus.row_out}, 16'h000E);
    repeat (8) @(negedge clk); check("row1", {12'h0, bus.row_out}, 16'h000D);
    repeat (8) @(negedge clk); check("row2", {12'h0, bus.row_out}, 16'h000B);
    repeat (8) @(negedge clk); check("row3", {12'h0, bus.row_out}, 16'h0007);
    repeat (2) wait_boundary();
    check("idle_valid_cnt", 16'(n_valid), 16'h0000);
    check("idle_entry", bus.entry, 16'h0000);

    // Clean press of key 9 (row 2, col 1)
    v0 = n_valid;
    set_keys(16'h0200);
    wait_boundary();
    set_keys(16'h0000);
    @(negedge clk);
    check("k9_valid", {15'h0, bus.key_valid}, 16'h0001);
    check("k9_code", {12'h0, bus.key_code}, 16'h0009);
    check("k9_entry", bus.entry, 16'h0009);
    check("k9_held", {15'h0, bus.key_held}, 16'h0001);
    repeat (3) wait_boundary();
    check("k9_released", {15'h0, bus.key_held}, 16'h0000);
    check("k9_one_pulse", 16'(n_valid - v0), 16'h0001);

    // One-scan glitch on key 3
    v0 = n_valid;
    set_keys(16'h0008);
    set_keys(16'h0000);
    repeat (2) wait_boundary();
    check("glitch_no_valid", 16'(n_valid - v0), 16'h0000);
    check("glitch_entry", bus.entry, 16'h0009);

    // Ghosting: keys 4 and 6 together
    set_keys(16'h0050);
    repeat (3) wait_boundary();
    set_keys(16'h0000);
    repeat (2) wait_boundary();
    check("multi_no_valid", 16'(n_valid - v0), 16'h0000);
    check("multi_entry", bus.entry, 16'h0009);

    // Sequence 1..5, then clear on key 6 accept
    for (int k = 1; k <= 5; k++) press_release(k);
    check("seq_entry", bus.entry, 16'h2345);
    set_keys(16'h0040);
    wait_boundary();
    set_keys(16'h0000);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_valid", {15'h0, bus.key_valid}, 16'h0001);
    check("clr_code", {12'h0, bus.key_code}, 16'h0006);
    check("clr_entry", bus.entry, 16'h0000);
    repeat (3) wait_boundary();

    // Reset while key 7 is held, then re-debounce after release of reset
    set_keys(16'h0080);
    repeat (3) wait_boundary();
    check("k7_held", {15'h0, bus.key_held}, 16'h0001);
    v0 = n_valid;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_row", {12'h0, bus.row_out}, 16'h000E);
    check("rst_code", {12'h0, bus.key_code}, 16'h0000);
    check("rst_valid", {15'h0, bus.key_valid}, 16'h0000);
    check("rst_held", {15'h0, bus.key_held}, 16'h0000);
    check("rst_entry", bus.entry, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) wait_boundary();
    check("post_rst_pulses", 16'(n_valid - v0), 16'h0001);
    check("post_rst_code", {12'h0, last_code}, 16'h0007);
    set_keys(16'h0000);
    repeat (3) wait_boundary();

    // Random key sets held for random numbers of scans, with occasional clears
    repeat (60) begin
      r = $urandom_range(0, 9);
      if (r < 4) m = 16'h0000;
      else if (r < 8) m = 16'(1) << $urandom_range(0, 15);
      else begin
        a = $urandom_range(0, 15);
        b = (a + $urandom_range(1, 15)) % 16;
        m = (16'(1) << a) | (16'(1) << b);
      end
      hold = $urandom_range(1, 4);
      set_keys(m);
      if ($urandom_range(0, 5) == 0) begin
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
      end
      repeat (hold - 1) wait_boundary();
    end
    set_keys(16'h0000);
    repeat (3) wait_boundary();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
